// File: rtl/data_memory_ctrl.sv
// RV32I byte-addressable data memory with a req/done handshake and programmable
// wait states; little-endian LB/LH/LW/LBU/LHU/SB/SH/SW with fault detection.
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic        Wr,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  output logic        Ready,
  output logic        Done,
  output logic [31:0] Dout,
  output logic        Fault
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        c_wr;
  logic [2:0]  c_f3;
  logic [31:0] c_addr, c_din;
  logic [7:0]  mem [DEPTH_BYTES];

  logic          access;
  logic [2:0]    size;
  logic          legal, misaligned, out_of_range, fault_c;
  logic [32:0]   last;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   rdata, ext, load_data;

  assign access = (state == S_WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nx = state;
    Ready    = 1'b0;
    Done     = 1'b0;
    case (state)
      S_IDLE: begin
        Ready = 1'b1;
        if (Req) state_nx = S_WAIT;
      end
      S_WAIT: if (cnt == 4'd0) state_nx = S_DONE;
      S_DONE: begin
        Done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Fault checks use only the captured request; range check in 33 bits so
  // addresses near 2^32 cannot wrap back into the array.
  always_comb begin
    case (c_f3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      2'b10:   size = 3'd4;
      default: size = 3'd0;
    endcase
    legal = c_wr ? (c_f3 inside {3'b000, 3'b001, 3'b010})
                 : (c_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((size == 3'd2) && c_addr[0]) ||
                   ((size == 3'd4) && (c_addr[1:0] != 2'b00));
    last         = {1'b0, c_addr} + {30'd0, size} - 33'd1;
    out_of_range = last >= 33'(DEPTH_BYTES);
    fault_c      = !legal || misaligned || out_of_range;
  end

  assign a0    = c_addr[AW-1:0];
  assign a1    = a0 + AW'(1);
  assign a2    = a0 + AW'(2);
  assign a3    = a0 + AW'(3);
  assign rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always_comb begin
    case (c_f3)
      3'b000:  ext = {{24{rdata[7]}}, rdata[7:0]};
      3'b001:  ext = {{16{rdata[15]}}, rdata[15:0]};
      3'b010:  ext = rdata;
      3'b100:  ext = {24'd0, rdata[7:0]};
      3'b101:  ext = {16'd0, rdata[15:0]};
      default: ext = 32'd0;
    endcase
    load_data = (c_wr || fault_c) ? 32'd0 : ext;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      c_wr   <= 1'b0;
      c_f3   <= 3'd0;
      c_addr <= 32'd0;
      c_din  <= 32'd0;
      Dout   <= 32'd0;
      Fault  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && Req) begin
        c_wr   <= Wr;
        c_f3   <= Funct3;
        c_addr <= Addr;
        c_din  <= Din;
        cnt    <= 4'(WAIT_STATES);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        Dout  <= load_data;
        Fault <= fault_c;
      end
    end
  end

  // Storage is not reset; reset on the access edge suppresses the write.
  always_ff @(posedge Clk) begin
    if (Rst_n && access && c_wr && !fault_c) begin
      mem[a0] <= c_din[7:0];
      if (size != 3'd1) mem[a1] <= c_din[15:8];
      if (size == 3'd4) begin
        mem[a2] <= c_din[23:16];
        mem[a3] <= c_din[31:24];
      end
    end
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, byte-addressable RV32I data memory with a request/done handshake and a configurable access latency. It executes all RV32I load and store widths in little-endian order: LB, LH, LW, LBU, LHU, SB, SH and SW. It sign- or zero-extends read data and flags misaligned, out-of-range and illegal accesses. It sits between the core's memory stage and the byte-array storage, and lets the pipeline be exercised against slow memory by setting wait states.

## Interface
Parameters:
- DEPTH_BYTES, 1024: storage size in bytes. Must be a power of two, minimum 4.
- WAIT_STATES, 1: extra cycles inserted before each access. Range 0..15.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Req  input  1  request; sampled only while Ready=1.
- Wr  input  1  1 = store, 0 = load.
- Funct3  input  3  RV32I funct3 giving access width and signedness.
- Addr  input  32  byte address.
- Din  input  32  store data; the low bytes are used for SB and SH.
- Ready  output  1  high in IDLE only; a request is accepted on an edge where Req=1 and Ready=1.
- Done  output  1  one-cycle pulse that completes the accepted request.
- Dout  output  32  registered, extended load data. Valid while Done=1 and held until the next access edge.
- Fault  output  1  valid with Done. When 1, the access was not performed.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: Ready=1. On Req=1, the block:
  - captures Wr, Funct3, Addr and Din;
  - loads the wait counter with WAIT_STATES;
  - moves to WAIT.
- WAIT: Ready=0.
  - If the counter ≠ 0, it decrements by 1.
  - If the counter = 0, this edge is the access edge: the access executes, Dout and Fault are registered, and the state moves to DONE.
- DONE: Done=1, Ready=0. Always returns to IDLE on the next edge.
- Inputs are used only from the captured copy. Changes to Req, Addr or Din after acceptance have no effect.
- Req asserted in WAIT or DONE is ignored. There is no queueing, and the requester must hold Req until Ready.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Fault conditions, evaluated on captured values at the access edge:
  - any funct3 not listed as legal for that direction;
  - misaligned: halfword with Addr[0]≠0, or word with Addr[1:0]≠0;
  - out of range: Addr + size − 1 ≥ DEPTH_BYTES. The comparison is done in 33 bits, so addresses near 2^32 do not wrap.
- On a fault: no byte is written, Dout=0 and Fault=1.
- Store, little-endian:
  - SB writes byte Addr ← Din[7:0].
  - SH also writes Addr+1 ← Din[15:8].
  - SW also writes Addr+2 ← Din[23:16] and Addr+3 ← Din[31:24].
  - Stores set Dout=0.
- Load, assembled as {M[A+3],M[A+2],M[A+1],M[A]}:
  - LB sign-extends bit 7; LBU zero-extends the byte.
  - LH sign-extends bit 15; LHU zero-extends the halfword.
  - LW returns the full word.
- Storage contents are not reset and are undefined until written.

## Timing
- Request accepted at edge E0. Access edge is E0+WAIT_STATES+1. Done is high in the following cycle. The state is IDLE again after E0+WAIT_STATES+2.
- Minimum issue-to-issue interval: WAIT_STATES+3 cycles. With WAIT_STATES=0 this is 3.
- A store is visible to a load whose access edge is any later edge.
- Reset values: state IDLE, counter 0, Ready=1 in the first cycle after reset, Done=0, Fault=0, Dout=0.
- Reset has priority over all activity. Rst_n=0 on an access edge aborts the request: no write occurs and no Done is produced. Rst_n=0 in WAIT or DONE returns the FSM to IDLE.
- Req and Rst_n=0 on the same edge: the request is not accepted.

## Test plan
- Reset, then SW 0x8badf00d to Addr 0x10, then LW from 0x10. Required: Dout=0x8badf00d, Fault=0, and Done exactly WAIT_STATES+2 cycles after Req is accepted.
- Same data at 0x10, then:
  - LB 0x13 → 0xffffff8b;
  - LBU 0x13 → 0x0000008b;
  - LH 0x12 → 0xffff8bad;
  - LHU 0x10 → 0x0000f00d.
- SB 0x77 to 0x11 over the word 0x8badf00d, then LW 0x10 → 0x8bad770d. Other bytes must be untouched.
- Each of the following returns Fault=1 and Dout=0, and memory is unchanged when checked with LW:
  - LW at 0x02;
  - SH at 0x05;
  - Funct3=011 load;
  - SW to DEPTH_BYTES−2;
  - LW at 0xFFFFFFFC.
- With WAIT_STATES=3, toggle Req and Addr during WAIT. Required: Ready=0 throughout WAIT and DONE, and the result reflects only the captured request.
- With WAIT_STATES=2, issue SW 0x12345678 to 0x20 and pull Rst_n low on the access edge. Required: no Done, and a subsequent LW of 0x20 does not return 0x12345678 (pre-load 0 at 0x20 first).
